evr_map_ram_bank_ctrl: RTL and testbench

//   Parametrised multi-bank event-mapping RAM controller for the EVR.

---
 rtl/evr_map_ram_bank_ctrl.sv | 156 +++++++++++++++
 tb/tb_evr_map_ram_bank_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/evr_map_ram_bank_ctrl.sv
// Multi-bank event-mapping RAM: host writes (edge-triggered, optional auto-increment),
// event-code lookup from a separately selected bank, and a hardware clear engine.
module evr_map_ram_bank_ctrl #(
  parameter  int NUM_BANKS = 2,
  parameter  int ADDR_W    = 8,
  parameter  int DATA_W    = 16,
  localparam int BSEL_W    = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              map_en_i,
  input  logic [BSEL_W-1:0] rd_bank_i,
  input  logic [BSEL_W-1:0] wr_bank_i,
  input  logic              autoinc_i,
  input  logic              ptr_rst_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              host_wr_i,
  input  logic              clr_req_i,
  input  logic              clr_all_i,
  input  logic [ADDR_W-1:0] ev_code_i,
  input  logic              ev_valid_i,
  output logic [DATA_W-1:0] map_o,
  output logic              map_valid_o,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic              wr_drop_o,
  output logic              clr_busy_o,
  output logic              clr_done_o
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [BSEL_W:0]   NB    = (BSEL_W + 1)'(NUM_BANKS);
  localparam logic [ADDR_W-1:0] LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                clr_all_q, clr_all_d;
  logic [BSEL_W-1:0]   clr_bank_q, clr_bank_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                host_wr_q;
  logic                drop_q, drop_d;
  logic [DATA_W-1:0]   map_q, map_d;
  logic                map_valid_q, map_valid_d;

  logic                host_act, host_we;
  logic [ADDR_W-1:0]   host_addr;
  logic                rd_bank_bad, rd_clearing;
  logic [DATA_W-1:0]   rd_word;
  logic [NUM_BANKS-1:0][DATA_W-1:0] bank_rd;

  // Host write qualification; the pointer moves on every enabled autoinc edge, even dropped ones.
  always_comb begin
    host_act  = host_wr_i & ~host_wr_q & map_en_i;
    host_addr = autoinc_i ? ptr_q : wr_addr_i;
    drop_d    = host_act & ((host_addr == '0) | ({1'b0, wr_bank_i} >= NB) |
                            (state_q != ST_IDLE) | clr_req_i);
    host_we   = host_act & ~drop_d;
    ptr_d     = ptr_q;
    if (ptr_rst_i) begin
      ptr_d = ONE;
    end else if (host_act && autoinc_i) begin
      ptr_d = (ptr_q == LAST) ? ONE : ptr_q + ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_all_d  = clr_all_q;
    clr_bank_d = clr_bank_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req_i) begin
          clr_all_d  = clr_all_i;
          clr_bank_d = wr_bank_i;
          clr_addr_d = '0;
          state_d    = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_addr_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          clr_addr_d = clr_addr_q + ONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Each bank owns its storage; clear and host writes never overlap since edges drop outside IDLE.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we, bank_we;

    assign clr_we     = (state_q == ST_CLEAR) && (clr_all_q || (clr_bank_q == BSEL_W'(g)));
    assign bank_we    = host_we && (wr_bank_i == BSEL_W'(g));
    assign bank_rd[g] = mem[ev_code_i];

    always_ff @(posedge clk_i) begin
      if (clr_we) begin
        mem[clr_addr_q] <= '0;
      end else if (bank_we) begin
        mem[host_addr] <= wr_data_i;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_bank_i == BSEL_W'(b)) rd_word = bank_rd[b];
    end
    rd_bank_bad = ({1'b0, rd_bank_i} >= NB);
    rd_clearing = (state_q == ST_CLEAR) && (clr_all_q || (clr_bank_q == rd_bank_i));
    map_valid_d = ev_valid_i & map_en_i;
    map_d       = '0;
    if (map_valid_d && !rd_bank_bad && !rd_clearing) map_d = rd_word;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      clr_addr_q  <= '0;
      clr_all_q   <= 1'b0;
      clr_bank_q  <= '0;
      ptr_q       <= ONE;
      host_wr_q   <= 1'b0;
      drop_q      <= 1'b0;
      map_q       <= '0;
      map_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_all_q   <= clr_all_d;
      clr_bank_q  <= clr_bank_d;
      ptr_q       <= ptr_d;
      host_wr_q   <= host_wr_i;
      drop_q      <= drop_d;
      map_q       <= map_d;
      map_valid_q <= map_valid_d;
    end
  end

  assign map_o       = map_q;
  assign map_valid_o = map_valid_q;
  assign wr_ptr_o    = ptr_q;
  assign wr_drop_o   = drop_q;
  assign clr_busy_o  = (state_q != ST_IDLE);
  assign clr_done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_evr_map_ram_bank_ctrl.sv
// Directed self-checking bench for evr_map_ram_bank_ctrl, built with three banks
// so an out-of-range bank select is reachable.
module tb_evr_map_ram_bank_ctrl;
  localparam int NB = 3;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int BW = 2;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          map_en_i, autoinc_i, ptr_rst_i, host_wr_i, clr_req_i, clr_all_i, ev_valid_i;
  logic [BW-1:0] rd_bank_i, wr_bank_i;
  logic [AW-1:0] wr_addr_i, ev_code_i;
  logic [DW-1:0] wr_data_i;
  logic [DW-1:0] map_o;
  logic          map_valid_o, wr_drop_o, clr_busy_o, clr_done_o;
  logic [AW-1:0] wr_ptr_o;

  int totalCount = 0;
  int badCount   = 0;

  always #5 clk_i = ~clk_i;

  evr_map_ram_bank_ctrl #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .map_en_i(map_en_i), .rd_bank_i(rd_bank_i),
    .wr_bank_i(wr_bank_i), .autoinc_i(autoinc_i), .ptr_rst_i(ptr_rst_i),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .host_wr_i(host_wr_i),
    .clr_req_i(clr_req_i), .clr_all_i(clr_all_i), .ev_code_i(ev_code_i),
    .ev_valid_i(ev_valid_i), .map_o(map_o), .map_valid_o(map_valid_o),
    .wr_ptr_o(wr_ptr_o), .wr_drop_o(wr_drop_o), .clr_busy_o(clr_busy_o),
    .clr_done_o(clr_done_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One host_wr rising edge; drop is the registered pulse seen right after the edge cycle.
  task automatic hostWrite(input logic [BW-1:0] bank, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, output logic drop);
    wr_bank_i = bank;
    wr_addr_i = addr;
    wr_data_i = data;
    host_wr_i = 1'b1;
    tick();
    drop      = wr_drop_o;
    host_wr_i = 1'b0;
    tick();
  endtask

  task automatic lookupMap(input logic [BW-1:0] bank, input logic [AW-1:0] code,
                           output logic [DW-1:0] data, output logic valid);
    rd_bank_i  = bank;
    ev_code_i  = code;
    ev_valid_i = 1'b1;
    tick();
    data       = map_o;
    valid      = map_valid_o;
    ev_valid_i = 1'b0;
  endtask

  task automatic waitClear(output int clearCycles, output int doneCycles);
    clearCycles = 0;
    doneCycles  = 0;
    for (int i = 0; i < 600; i++) begin
      if (clr_busy_o && !clr_done_o) clearCycles++;
      if (clr_done_o) doneCycles++;
      if (!clr_busy_o) break;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] data;
    logic          valid, drop;
    int            clrCyc, doneCyc, errs, drops;
    logic [AW-1:0] codes [6];

    rst_n_i = 1'b0; map_en_i = 1'b1; autoinc_i = 1'b0; ptr_rst_i = 1'b0; host_wr_i = 1'b0;
    clr_req_i = 1'b0; clr_all_i = 1'b0; ev_valid_i = 1'b0; rd_bank_i = '0; wr_bank_i = '0;
    wr_addr_i = '0; ev_code_i = '0; wr_data_i = '0;
    #12;
    checkOutput("rst_ptr", wr_ptr_o, 32'h1);
    checkOutput("rst_busy", clr_busy_o, 0);
    checkOutput("rst_done", clr_done_o, 0);
    checkOutput("rst_valid", map_valid_o, 0);
    checkOutput("rst_map", map_o, 0);
    checkOutput("rst_drop", wr_drop_o, 0);
    tick();
    rst_n_i = 1'b1;
    tick();

    // Clear everything, then every code of every bank must read zero.
    clr_all_i = 1'b1; clr_req_i = 1'b1;
    tick();
    clr_req_i = 1'b0; clr_all_i = 1'b0;
    waitClear(clrCyc, doneCyc);
    checkOutput("clrall_cycles", clrCyc, 256);
    checkOutput("clrall_done", doneCyc, 1);
    for (int b = 0; b < NB; b++) begin
      errs = 0;
      for (int c = 0; c < 256; c++) begin
        lookupMap(BW'(b), AW'(c), data, valid);
        if (data !== '0 || valid !== 1'b1) errs++;
      end
      checkOutput($sformatf("clrall_zero_b%0d", b), errs, 0);
    end

    // Auto-increment writes into bank 1.
    autoinc_i = 1'b1; ptr_rst_i = 1'b1;
    tick();
    ptr_rst_i = 1'b0;
    checkOutput("ptr_after_rst", wr_ptr_o, 1);
    hostWrite(1, 8'h00, 16'h00A1, drop); checkOutput("ai_drop1", drop, 0);
    hostWrite(1, 8'h00, 16'h00A2, drop); checkOutput("ai_drop2", drop, 0);
    hostWrite(1, 8'h00, 16'h00A3, drop); checkOutput("ai_drop3", drop, 0);
    checkOutput("ai_ptr", wr_ptr_o, 4);
    lookupMap(1, 8'h01, data, valid); checkOutput("ai_b1_c1", data, 16'h00A1);
    checkOutput("ai_b1_valid", valid, 1);
    lookupMap(1, 8'h02, data, valid); checkOutput("ai_b1_c2", data, 16'h00A2);
    lookupMap(1, 8'h03, data, valid); checkOutput("ai_b1_c3", data, 16'h00A3);
    lookupMap(0, 8'h02, data, valid); checkOutput("ai_b0_c2", data, 0);

    // Disabled map: edges ignored silently, lookups produce nothing.
    map_en_i = 1'b0;
    hostWrite(1, 8'h00, 16'h5555, drop); checkOutput("dis_drop", drop, 0);
    checkOutput("dis_ptr", wr_ptr_o, 4);
    lookupMap(1, 8'h01, data, valid); checkOutput("dis_valid", valid, 0);
    checkOutput("dis_map", data, 0);
    map_en_i = 1'b1;
    lookupMap(1, 8'h04, data, valid); checkOutput("dis_nowrite", data, 0);

    // Direct addressing, reserved address 0.
    autoinc_i = 1'b0;
    hostWrite(1, 8'h00, 16'h9999, drop); checkOutput("addr0_drop", drop, 1);
    lookupMap(1, 8'h00, data, valid); checkOutput("addr0_data", data, 0);
    hostWrite(1, 8'hFF, 16'h1234, drop); checkOutput("ff_drop", drop, 0);
    lookupMap(1, 8'hFF, data, valid); checkOutput("ff_data", data, 16'h1234);
    checkOutput("ff_valid", valid, 1);
    tick();
    checkOutput("valid_pulse", map_valid_o, 0);

    // Lookup and write to the same word in one cycle returns the old word.
    hostWrite(0, 8'h10, 16'h1111, drop);
    rd_bank_i = 0; ev_code_i = 8'h10; ev_valid_i = 1'b1;
    wr_bank_i = 0; wr_addr_i = 8'h10; wr_data_i = 16'h2222; host_wr_i = 1'b1;
    tick();
    checkOutput("rdfirst_old", map_o, 16'h1111);
    ev_valid_i = 1'b0; host_wr_i = 1'b0;
    tick();
    lookupMap(0, 8'h10, data, valid); checkOutput("rdfirst_new", data, 16'h2222);

    // Single-bank clear of bank 1 with host edges colliding with it.
    wr_bank_i = 1; wr_addr_i = 8'h05; wr_data_i = 16'h7777; host_wr_i = 1'b1;
    clr_req_i = 1'b1; clr_all_i = 1'b0;
    tick();
    checkOutput("clrreq_drop", wr_drop_o, 1);
    checkOutput("clrreq_busy", clr_busy_o, 1);
    clr_req_i = 1'b0; host_wr_i = 1'b0;
    tick();
    hostWrite(1, 8'h06, 16'h8888, drop); checkOutput("inclr_drop", drop, 1);
    lookupMap(1, 8'h02, data, valid); checkOutput("inclr_b1_data", data, 0);
    checkOutput("inclr_b1_valid", valid, 1);
    lookupMap(0, 8'h10, data, valid); checkOutput("inclr_b0_data", data, 16'h2222);
    waitClear(clrCyc, doneCyc);
    checkOutput("clr1_done", doneCyc, 1);
    codes = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'hFF};
    errs = 0;
    foreach (codes[i]) begin
      lookupMap(1, codes[i], data, valid);
      if (data !== '0) errs++;
    end
    checkOutput("clr1_b1_zero", errs, 0);
    lookupMap(0, 8'h10, data, valid); checkOutput("clr1_b0_kept", data, 16'h2222);

    // Pointer wrap: walk to 0xFF with dropped edges on an out-of-range bank.
    autoinc_i = 1'b1; ptr_rst_i = 1'b1;
    tick();
    ptr_rst_i = 1'b0;
    drops = 0;
    for (int i = 0; i < 254; i++) begin
      hostWrite(3, 8'h00, 16'hDEAD, drop);
      if (drop === 1'b1) drops++;
    end
    checkOutput("badbank_drops", drops, 254);
    checkOutput("ptr_ff", wr_ptr_o, 8'hFF);
    hostWrite(2, 8'h00, 16'hBEEF, drop); checkOutput("wrap_drop", drop, 0);
    checkOutput("wrap_ptr", wr_ptr_o, 1);
    lookupMap(2, 8'hFF, data, valid); checkOutput("wrap_data", data, 16'hBEEF);
    lookupMap(3, 8'h01, data, valid); checkOutput("badrd_valid", valid, 1);
    checkOutput("badrd_map", data, 0);
    hostWrite(2, 8'h00, 16'h0B0B, drop);
    checkOutput("ptr_two", wr_ptr_o, 2);
    ptr_rst_i = 1'b1;
    hostWrite(2, 8'h00, 16'h0C0C, drop);
    ptr_rst_i = 1'b0;
    checkOutput("ptrrst_wins", wr_ptr_o, 1);
    lookupMap(2, 8'h02, data, valid); checkOutput("ptrrst_data", data, 16'h0C0C);

    // Reset in the middle of a clear-all at address 0x40.
    autoinc_i = 1'b0;
    hostWrite(0, 8'h20, 16'h2020, drop);
    hostWrite(0, 8'h40, 16'h4040, drop);
    hostWrite(0, 8'h80, 16'h8080, drop);
    autoinc_i = 1'b1;
    hostWrite(3, 8'h00, 16'h0000, drop);
    autoinc_i = 1'b0;
    checkOutput("pre_rst_ptr", wr_ptr_o, 2);
    lookupMap(0, 8'h40, data, valid); checkOutput("pre_rst_data", data, 16'h4040);
    clr_all_i = 1'b1; clr_req_i = 1'b1;
    tick();
    clr_req_i = 1'b0; clr_all_i = 1'b0;
    repeat (8'h40) tick();
    checkOutput("mid_busy", clr_busy_o, 1);
    rst_n_i = 1'b0;
    #1;
    checkOutput("async_busy", clr_busy_o, 0);
    checkOutput("async_ptr", wr_ptr_o, 1);
    checkOutput("async_done", clr_done_o, 0);
    checkOutput("async_valid", map_valid_o, 0);
    tick();
    rst_n_i = 1'b1;
    doneCyc = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (clr_done_o || clr_busy_o) doneCyc++;
    end
    checkOutput("abort_nodone", doneCyc, 0);
    lookupMap(0, 8'h20, data, valid); checkOutput("abort_low_cleared", data, 0);
    lookupMap(0, 8'h40, data, valid); checkOutput("abort_40_kept", data, 16'h4040);
    lookupMap(0, 8'h80, data, valid); checkOutput("abort_80_kept", data, 16'h8080);
    lookupMap(2, 8'hFF, data, valid); checkOutput("abort_b2_kept", data, 16'hBEEF);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end
endmodule
